// File: rtl/qspi_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : qspi_sram_responder_if
// Purpose  : Quad-SPI (SQI) serial SRAM bus bundle between an initiator and
//            the SRAM responder.
// Revision : 1.0 - initial release
// ============================================================================
interface qspi_sram_responder_if;
    logic       cs_n;
    logic       sck;
    logic [3:0] sio_i;
    logic [3:0] sio_o;
    logic       sio_oe;

    modport master (output cs_n, output sck, output sio_i,
                    input  sio_o, input  sio_oe);
    modport slave  (input  cs_n, input  sck, input  sio_i,
                    output sio_o, output sio_oe);
endinterface
`default_nettype wire

// File: rtl/qspi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : qspi_sram_responder
// Purpose  : 23LC1024-style SQI sequential-mode serial SRAM responder. sck,
//            cs_n and sio are oversampled on clk; there is no sck-domain logic.
// Revision : 1.0 - initial release
// ============================================================================
module qspi_sram_responder #(
    parameter int DEPTH       = 4096,
    parameter int AW          = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    qspi_sram_responder_if.slave  bus,
    output logic                  cmd_err,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DUMMY  = 3'd3,
        S_READ   = 3'd4,
        S_WRITE  = 3'd5,
        S_IGNORE = 3'd6
    } state_t;

    // Reset: asserts asynchronously, releases on clk.
    logic rst_meta_q, rst_n_q;

    // Reset release synchronizer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    // Equal-depth synchronizers so cs_n, sck and sio stay aligned.
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [3:0]             sio_sync_q [SYNC_STAGES];
    logic                   sck_prev_q;

    // Shift the initiator's signals through the synchronizer chains.
    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            cs_sync_q  <= '1;
            sck_sync_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sio_sync_q[i] <= 4'h0;
            sck_prev_q <= 1'b0;
        end else begin
            cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
            sck_sync_q    <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
            sio_sync_q[0] <= bus.sio_i;
            for (int i = 1; i < SYNC_STAGES; i++) sio_sync_q[i] <= sio_sync_q[i-1];
            sck_prev_q    <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    logic       cs_n_s, sck_s, sck_rise, sck_fall;
    logic [3:0] sio_s;
    assign cs_n_s   = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign sio_s    = sio_sync_q[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s &  sck_prev_q;

    state_t        state_q;
    logic [2:0]    cnt_q;
    logic [3:0]    cmd_hi_q;
    logic          is_write_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    hi_q;
    logic          phase_q;
    logic [3:0]    sio_o_q;
    logic          sio_oe_q;
    logic          cmd_err_q;
    logic          busy_q;

    // Backing store: deliberately not reset so contents survive reset.
    logic [7:0]    mem [DEPTH];
    logic [7:0]    mem_rd;
    logic          mem_we;
    logic [AW+3:0] addr_shift;

    assign mem_rd     = mem[addr_q];
    assign addr_shift = {addr_q, sio_s};
    // A byte commits only on its low-nibble rise while still selected.
    assign mem_we     = (state_q == S_WRITE) && !cs_n_s && sck_rise && phase_q;

    // Memory write port.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= {hi_q, sio_s};
    end

    // Protocol state machine; deselect takes priority over any sck edge.
    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            cmd_hi_q   <= 4'h0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            hi_q       <= 4'h0;
            phase_q    <= 1'b0;
            sio_o_q    <= 4'h0;
            sio_oe_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cmd_err_q <= 1'b0;
            if (cs_n_s) begin
                if (state_q != S_IDLE) begin
                    state_q  <= S_IDLE;
                    sio_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_CMD;
                        busy_q  <= 1'b1;
                        cnt_q   <= 3'd0;
                        addr_q  <= '0;
                        phase_q <= 1'b0;
                    end
                    S_CMD: if (sck_rise) begin
                        if (cnt_q == 3'd0) begin
                            cmd_hi_q <= sio_s;
                            cnt_q    <= 3'd1;
                        end else begin
                            cnt_q <= 3'd0;
                            if ({cmd_hi_q, sio_s} == 8'h03) begin
                                is_write_q <= 1'b0;
                                state_q    <= S_ADDR;
                            end else if ({cmd_hi_q, sio_s} == 8'h02) begin
                                is_write_q <= 1'b1;
                                state_q    <= S_ADDR;
                            end else begin
                                cmd_err_q <= 1'b1;
                                state_q   <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR: if (sck_rise) begin
                        // Upper address bits fall off the top: aliasing.
                        addr_q <= addr_shift[AW-1:0];
                        if (cnt_q == 3'd5) begin
                            cnt_q   <= 3'd0;
                            phase_q <= 1'b0;
                            state_q <= is_write_q ? S_WRITE : S_DUMMY;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                    S_DUMMY: if (sck_rise) begin
                        if (cnt_q == 3'd1) begin
                            cnt_q   <= 3'd0;
                            phase_q <= 1'b0;
                            state_q <= S_READ;
                        end else begin
                            cnt_q <= 3'd1;
                        end
                    end
                    S_READ: if (sck_fall) begin
                        if (!phase_q) begin
                            sio_oe_q <= 1'b1;
                            sio_o_q  <= mem_rd[7:4];
                            phase_q  <= 1'b1;
                        end else begin
                            sio_o_q  <= mem_rd[3:0];
                            addr_q   <= addr_q + 1'b1;
                            phase_q  <= 1'b0;
                        end
                    end
                    S_WRITE: if (sck_rise) begin
                        if (!phase_q) begin
                            hi_q    <= sio_s;
                            phase_q <= 1'b1;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            phase_q <= 1'b0;
                        end
                    end
                    S_IGNORE: sio_oe_q <= 1'b0;
                    default:  state_q  <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.sio_o  = sio_o_q;
    assign bus.sio_oe = sio_oe_q;
    assign cmd_err    = cmd_err_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_qspi_sram_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_qspi_sram_responder
// Purpose  : Self-checking bench for qspi_sram_responder, acting as an SQI
//            initiator with a byte-array reference of the memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qspi_sram_responder;

    localparam int DEPTH = 4096;
    localparam int SYNC  = 2;
    localparam int HALF  = 6;   // clk cycles per sck half period

    logic clk = 1'b0;
    logic reset_n;
    logic cmd_err;
    logic busy;

    qspi_sram_responder_if bus ();

    qspi_sram_responder #(.DEPTH(DEPTH), .AW(12), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .cmd_err (cmd_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         err_pulses = 0;
    logic [7:0] model_mem [DEPTH];
    bit         model_valid [DEPTH];
    logic [7:0] wq [$];

    // Count clk cycles on which cmd_err is high.
    always @(negedge clk) begin
        if (cmd_err === 1'b1) err_pulses <= err_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One sck cycle: present data while low, sample responder just before rise.
    task automatic nib(input logic [3:0] d, output logic [3:0] q, output logic oe);
        bus.sio_i = d;
        tick(HALF);
        q  = bus.sio_o;
        oe = bus.sio_oe;
        bus.sck = 1'b1;
        tick(HALF);
        bus.sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        logic [3:0] q;
        logic       oe;
        nib(b[7:4], q, oe);
        check({tag, "_oe_hi"}, oe, 0);
        nib(b[3:0], q, oe);
        check({tag, "_oe_lo"}, oe, 0);
    endtask

    task automatic cs_begin();
        bus.cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_end(input string tag);
        tick(HALF);
        bus.cs_n = 1'b1;
        tick(SYNC + 1);
        check({tag, "_busy_drop"}, busy, 0);
        check({tag, "_oe_drop"}, bus.sio_oe, 0);
        tick(4);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a, input string tag);
        send_byte(cmd, {tag, "_cmd"});
        send_byte(a[23:16], {tag, "_a2"});
        send_byte(a[15:8],  {tag, "_a1"});
        send_byte(a[7:0],   {tag, "_a0"});
    endtask

    // Sequential write of wq starting at a; model updated per byte.
    task automatic do_write(input logic [23:0] a, input string tag);
        int idx;
        cs_begin();
        send_hdr(8'h02, a, tag);
        foreach (wq[i]) begin
            send_byte(wq[i], {tag, "_wd"});
            idx = (int'(a) + i) % DEPTH;
            model_mem[idx]   = wq[i];
            model_valid[idx] = 1'b1;
        end
        cs_end(tag);
    endtask

    // Sequential read of n bytes starting at a, checked against the model.
    task automatic do_read(input logic [23:0] a, input int n, input string tag);
        logic [3:0] hi, lo;
        logic       oe_h, oe_l;
        int         idx;
        cs_begin();
        send_hdr(8'h03, a, tag);
        send_byte(8'h00, {tag, "_dummy"});
        for (int i = 0; i < n; i++) begin
            nib(4'h0, hi, oe_h);
            nib(4'h0, lo, oe_l);
            check($sformatf("%s_oe[%0d]", tag, i), {oe_h, oe_l}, 2'b11);
            idx = (int'(a) + i) % DEPTH;
            if (model_valid[idx])
                check($sformatf("%s_data[%0d]", tag, i), {hi, lo}, model_mem[idx]);
        end
        cs_end(tag);
    endtask

    initial begin
        logic [3:0]  q;
        logic        oe;
        int          p0;
        logic [23:0] ra, wa;
        int          n;

        foreach (model_valid[i]) model_valid[i] = 1'b0;
        bus.cs_n  = 1'b1;
        bus.sck   = 1'b0;
        bus.sio_i = 4'h0;
        reset_n   = 1'b0;
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_oe", bus.sio_oe, 0);
        check("rst_cmd_err", cmd_err, 0);
        reset_n = 1'b1;
        tick(5);

        // Write then read back.
        wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h3C);
        do_write(24'h000010, "wr10");
        do_read(24'h000010, 2, "rd10");

        // Wrap from the top of memory to address 0.
        wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
        do_write(24'(DEPTH - 1), "wrwrap");
        do_read(24'(DEPTH - 1), 2, "rdwrap");
        do_read(24'h000000, 1, "rd0");

        // Address aliasing above AW bits.
        wq.delete(); wq.push_back(8'h7E);
        do_write(24'h001005, "wralias");
        do_read(24'h000005, 1, "rdalias");

        // Unsupported command followed by further clocks.
        p0 = err_pulses;
        cs_begin();
        send_byte(8'h9F, "bad_cmd");
        for (int i = 0; i < 10; i++) begin
            nib(4'($urandom), q, oe);
            check($sformatf("bad_oe[%0d]", i), oe, 0);
        end
        cs_end("bad");
        check("bad_err_pulses", err_pulses - p0, 1);
        do_read(24'h000010, 2, "rd_after_bad");

        // Partial byte abort must leave the next byte untouched.
        wq.delete(); wq.push_back(8'h96);
        do_write(24'h000021, "wr21");
        cs_begin();
        send_hdr(8'h02, 24'h000020, "part");
        send_byte(8'h5A, "part_d");
        nib(4'hF, q, oe);
        cs_end("part");
        model_mem[32'h20]   = 8'h5A;
        model_valid[32'h20] = 1'b1;
        do_read(24'h000020, 2, "rdpart");

        // Reset during the read data phase.
        cs_begin();
        send_hdr(8'h03, 24'h000010, "rstrd");
        send_byte(8'h00, "rstrd_dummy");
        nib(4'h0, q, oe);
        check("rstrd_first_nib", {oe, q}, 5'h1A);
        reset_n = 1'b0;
        #1;
        check("rstrd_oe_async", bus.sio_oe, 0);
        check("rstrd_busy_async", busy, 0);
        tick(3);
        bus.cs_n = 1'b1;
        reset_n  = 1'b1;
        tick(6);
        do_read(24'h000010, 1, "rd_after_rst");

        // Randomized bursts, read back through an aliased address.
        for (int it = 0; it < 6; it++) begin
            wa = 24'($urandom);
            n  = $urandom_range(1, 4);
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
            do_write(wa, $sformatf("rndwr%0d", it));
            ra = wa ^ (24'($urandom_range(0, 4095)) << 12);
            do_read(ra, n, $sformatf("rndrd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qspi_sram_responder.md
Name: qspi_sram_responder

Overview:
- Synthesizable responder for the quad-SPI (SQI) serial SRAM protocol that the SoC's ram/rom/vram ports initiate.
- Models a 23LC1024-style device in SQI sequential mode, with an internal byte array.
- Used in FPGA bring-up and in bench harnesses as the far end of a `*_cs_n`/`*_sck`/`*_sio` bundle.
- Oversamples sck and cs_n on the system clock; no logic runs on the sck domain.

Parameters:
- DEPTH, 4096: bytes of backing storage; power of two.
- AW, 12: log2(DEPTH); internal address width.
- SYNC_STAGES, 2: synchronizer depth on sck, cs_n and sio_i; minimum 2.

Ports:
- clk  input  1: system clock; must be at least 4x the sck frequency.
- reset_n  input  1: asynchronous, active-low reset.
- cs_n  input  1: chip select from initiator, active low.
- sck  input  1: serial clock from initiator.
- sio_i  input  4: SIO lines from initiator; bit 0 = sio0.
- sio_o  output  4: SIO lines to initiator.
- sio_oe  output  1: high while responder drives SIO.
- cmd_err  output  1: one-clk pulse when an unsupported command byte is received.
- busy  output  1: high from cs_n falling (synchronized) until return to IDLE.

Behaviour:
- Reset (async assert, sync release): sio_o=0, sio_oe=0, cmd_err=0, busy=0, state=IDLE, address and nibble counters cleared. Memory array is NOT reset; contents persist across reset.
- Sampling:
  - cs_n, sck and sio_i pass through SYNC_STAGES flops each, so all three share equal delay.
  - rise = sck_s & ~sck_prev; fall = ~sck_s & sck_prev.
  - sio_i is sampled from the delayed copy on the clk of a rise.
- Nibble order: high nibble first for command, address and data. Inputs are captured on rise. Outputs update on the clk after a fall.
- State machine:
  - IDLE: on synchronized cs_n low -> CMD, busy=1, nibble count=0.
  - CMD: 2 rises capture the 8-bit command.
    - 0x03 -> ADDR (read).
    - 0x02 -> ADDR (write).
    - Any other value -> IGNORE, with cmd_err pulsed for 1 clk.
  - ADDR: 6 rises capture the 24-bit address. Bits [AW-1:0] are kept; upper bits are ignored (aliasing).
    - Read -> DUMMY.
    - Write -> WRITE.
  - DUMMY: 2 rises ignored (one dummy byte) -> READ.
  - READ: on each fall, drive the next nibble.
    - First fall after the last dummy rise: sio_oe=1, sio_o=mem[addr][7:4].
    - Next fall: mem[addr][3:0], then addr increments.
    - Continues until cs_n rises.
  - WRITE: rises alternate high/low nibble. On the low-nibble rise, commit mem[addr]={hi,lo} and increment addr.
  - IGNORE: sio_oe=0; all edges ignored until cs_n rises.
- Address wrap: addr DEPTH-1 increments to 0 for both read and write.
- cs_n rising (synchronized), in any state:
  - On the next clk: state=IDLE, sio_oe=0, busy=0.
  - A partially received write byte (high nibble only) is discarded.
  - A partial command or address aborts with no memory effect.
- sck edges while cs_n is high are ignored.
- A cs_n rise and an sck edge in the same clk: cs_n wins; the edge is dropped.
- Reset asserted mid-transaction: immediate return to IDLE, sio_oe=0. An in-flight write byte is not committed.
- sio_o holds its last value while sio_oe=0. The bench must not check sio_o when sio_oe=0.

Test Plan:
- Write then read:
  - Stimulus: cs_n low; WRITE 0x02, address 0x000010, data 0xA5 0x3C; cs_n high. Then READ 0x03, address 0x000010, dummy, 4 data nibbles.
  - Required: nibbles A,5,3,C in order; sio_oe rises only after the dummy byte; busy drops within SYNC_STAGES+1 clks of cs_n high.
- Wrap-around:
  - Stimulus: write 0x11 at DEPTH-1 and 0x22 in the same burst; then read 2 bytes from DEPTH-1.
  - Required: mem[4095]=0x11 and mem[0]=0x22; read returns 0x11, 0x22.
- Address aliasing:
  - Stimulus: write 0x7E to address 0x001005 (DEPTH=4096); read address 0x000005.
  - Required: read returns 0x7E.
- Unsupported command:
  - Stimulus: command 0x9F, followed by 10 further sck cycles.
  - Required: cmd_err high for exactly 1 clk; sio_oe stays 0; memory unchanged.
- Partial-byte abort:
  - Stimulus: WRITE at 0x20 with one full byte 0x5A, then only the high nibble 0xF; cs_n rises.
  - Required: mem[0x20]=0x5A; mem[0x21] keeps its prior value.
- Reset mid-read:
  - Stimulus: assert reset_n=0 during the READ data phase.
  - Required: sio_oe=0 and busy=0 asynchronously; after release, a new read of 0x10 still returns 0xA5 (memory preserved).
